keypad_scan_if: RTL and testbench
=================================

// Module: keypad_scan_if
// PURPOSE
//  Memory-mapped 4x4 matrix keypad scanner: the input-side counterpart of the scanned 7-seg display driver.
//  Drives one active-low column at a time, samples active-low rows, debounces whole-matrix frames and
//  queues one 4-bit key code per clean press in a small FIFO. Sits on the SoC data bus beside the
//  accelerators and GPIO: decoder supplies WE, mux4 returns OutData; done_sig flags a pending key.
// PARAMETERS
//  SCAN_DIV        5000  clk cycles each column is driven (settle + sample period); must be >= 2
//  DEBOUNCE_SCANS  4     consecutive identical full frames needed to accept a press or a release; >= 1
//  FIFO_DEPTH      4     key-code FIFO entries; power of 2, 2..16
// PORTS
//  clk      in   1   single clock; all state on posedge
//  rst      in   1   asynchronous, active-low reset
//  A        in   2   register select (dataadr[3:2])
//  WE       in   1   write strobe for register A, sampled on posedge clk
//  InData   in   32  write data
//  OutData  out  32  read data for register A, combinational from registered state
//  done_sig out  1   high while FIFO non-empty (registered)
//  col_n    out  4   column drive, active-low one-hot; 4'b1111 when disabled
//  row_n    in   4   row sense, active-low, asynchronous (external pull-ups)
// BEHAVIOUR
//  Reset (rst=0): col_n=4'b1111, FIFO empty, overflow=0, enable=1, debounce state RELEASED, count=0,
//   snapshot/prev frame=0, done_sig=0, scan FSM in IDLE; takes effect immediately and aborts any frame.
//  Registers:
//   A=0 STATUS  R: {26'b0, count[4:0], overflow}; bit0 = overflow. Writes ignored.
//   A=1 DATA    R: {28'b0, head code} (0 if empty). W (any data): pop head; pop on empty ignored.
//   A=2 CTRL    R: {31'b0, enable}. W: enable<=InData[0]; InData[1]=1 clears overflow.
//   A=3 RAW     R: {16'b0, last completed frame snapshot}. Writes ignored.
//  Row input: 2-flop synchronizer, inverted -> rows[3:0] (1 = pressed).
//  Scan FSM: IDLE -> DRIVE when enable=1. DRIVE: col_n drives column c low, divider counts 0..SCAN_DIV-1;
//   at SCAN_DIV-1 store rows into snap[4c+3:4c], c<=c+1. After c=3 -> FRAME (1 cycle, col_n=4'b1111),
//   then DRIVE c=0. enable=0 at any time -> IDLE next cycle, col_n=4'b1111, partial frame discarded,
//   debounce counter cleared; debounce state kept.
//  Frame period = 4*SCAN_DIV+1 cycles. Key code = 4*col + row (col 0..3, row 0..3).
//  Debounce (evaluated in FRAME): stable counter increments if snap==prev frame, else resets to 1;
//   prev<=snap. Saturates at DEBOUNCE_SCANS.
//   RELEASED: when stable reaches DEBOUNCE_SCANS and snap has exactly one bit set -> push code,
//     go PRESSED. More than one bit set -> go PRESSED with no push (ghosting/chord rejected).
//   PRESSED: when snap==0 stable for DEBOUNCE_SCANS frames -> RELEASED. Held key never repeats.
//  FIFO: push occurs on the FRAME cycle; done_sig and count update the following cycle.
//   Push when full: code dropped, overflow<=1 (sticky until CTRL write with bit1=1).
//   Simultaneous pop (DATA write) and push: both happen; when full this is not an overflow.
//   Simultaneous overflow set and clear: set wins.
//   Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4; frame = 17 cycles)
//  Reset: rst=0 mid-frame -> col_n=4'b1111, done_sig=0, STATUS=0, CTRL=1; rst=1 -> col_n=4'b1110 within 2 clks.
//  Press col2,row1 (row_n[1]=0 only while col_n[2]=0) for 3 frames -> DATA=32'h9, done_sig=1, STATUS count=1;
//   held 10 more frames -> still count=1; WE at A=1 -> done_sig=0, count=0.
//  Bounce: toggle key col0,row0 every frame for 5 frames, then release -> no push, count stays 0.
//  Two keys (col0,row0 + col3,row3) held 4 frames -> no push; RAW=16'h8001; release, press col1,row2 -> DATA=6.
//  Six distinct press/release cycles, no pops -> count=4, overflow=1, DATA order codes 1..4; write CTRL=3 -> overflow=0.
//  Write CTRL=0 mid-column -> col_n=4'b1111 next cycle, key pressed while disabled never queued; CTRL=1 resumes at col 0.

Source files
------------

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: memory-mapped 4x4 active-low matrix keypad scanner.
// Scans one column at a time, debounces whole 16-key frames and queues one
// 4-bit key code per clean single-key press in a small FIFO.
module keypad_scan_if #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  A,
  input  logic        WE,
  input  logic [31:0] InData,
  output logic [31:0] OutData,
  output logic        done_sig,
  output logic [3:0]  col_n,
  input  logic [3:0]  row_n
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);
  localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [4:0]       CNT_FULL = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FRAME} state_t;

  state_t            state_q, state_d;
  logic [3:0]        sync1_q, sync2_q;
  logic [3:0]        rows;
  logic [1:0]        col_q, col_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [15:0]       snap_q, snap_d;
  logic [15:0]       prev_q, prev_d;
  logic [STB_W-1:0]  stable_q, stable_d;
  logic              pressed_q, pressed_d;
  logic              enable_q, enable_d;
  logic              overflow_q, overflow_d;
  logic [4:0]        count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]        fifo_q [FIFO_DEPTH];
  logic [3:0]        fifo_d [FIFO_DEPTH];
  logic              done_q, done_d;
  logic              data_wr, ctrl_wr, frame_done, push, do_push, do_pop;
  logic [3:0]        push_code;
  logic              unused_indata;

  assign data_wr       = WE && (A == 2'd1);
  assign ctrl_wr       = WE && (A == 2'd2);
  assign enable_d      = ctrl_wr ? InData[0] : enable_q;
  assign rows          = ~sync2_q;
  assign done_sig      = done_q;
  assign unused_indata = ^InData[31:2];

  // Scan sequencer: walk the columns, capture each column's rows into the frame snapshot
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    div_d      = div_q;
    snap_d     = snap_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_d) begin
          state_d = S_DRIVE;
          col_d   = 2'd0;
          div_d   = '0;
        end
      end
      S_DRIVE: begin
        if (!enable_d) begin
          state_d = S_IDLE;
          col_d   = 2'd0;
          div_d   = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          snap_d[{col_q, 2'b00} +: 4] = rows;
          if (col_q == 2'd3) begin
            state_d = S_FRAME;
            col_d   = 2'd0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + DIV_ONE;
        end
      end
      S_FRAME: begin
        state_d    = enable_d ? S_DRIVE : S_IDLE;
        frame_done = enable_d;
        col_d      = 2'd0;
        div_d      = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Column drive decoded from the registered scan state
  always_comb begin
    col_n = 4'b1111;
    if (state_q == S_DRIVE) col_n = ~(4'b0001 << col_q);
  end

  // Frame debounce: accept a press or release only after a run of identical frames
  always_comb begin
    stable_d  = stable_q;
    prev_d    = prev_q;
    pressed_d = pressed_q;
    push      = 1'b0;
    push_code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap_q[i]) push_code = 4'(i);
    end
    if (!enable_d) begin
      stable_d = '0;
    end else if (frame_done) begin
      prev_d = snap_q;
      if (snap_q == prev_q) stable_d = (stable_q == STB_MAX) ? STB_MAX : stable_q + STB_ONE;
      else                  stable_d = STB_ONE;
      if (stable_d == STB_MAX) begin
        if (!pressed_q && (snap_q != 16'd0)) begin
          pressed_d = 1'b1;
          push      = $onehot(snap_q);
        end else if (pressed_q && (snap_q == 16'd0)) begin
          pressed_d = 1'b0;
        end
      end
    end
  end

  // Key-code FIFO with sticky overflow; a pop frees room for a same-cycle push
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    do_pop     = data_wr && (count_q != 5'd0);
    do_push    = push && ((count_q != CNT_FULL) || do_pop);
    if (do_push) begin
      fifo_d[wr_ptr_q] = push_code;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + 5'd1;
    else if (do_pop && !do_push) count_d = count_q - 5'd1;
    if (ctrl_wr && InData[1]) overflow_d = 1'b0;
    if (push && !do_push)     overflow_d = 1'b1;
    done_d = (count_d != 5'd0);
  end

  // Register read mux
  always_comb begin
    OutData = 32'd0;
    case (A)
      2'd0: OutData = {26'd0, count_q, overflow_q};
      2'd1: OutData = {28'd0, (count_q != 5'd0) ? fifo_q[rd_ptr_q] : 4'd0};
      2'd2: OutData = {31'd0, enable_q};
      2'd3: OutData = {16'd0, prev_q};
      default: OutData = 32'd0;
    endcase
  end

  // Row synchronizer; idle rows read as released
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
    end
  end

  // Scan, debounce and control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      col_q     <= 2'd0;
      div_q     <= '0;
      snap_q    <= 16'd0;
      prev_q    <= 16'd0;
      stable_q  <= '0;
      pressed_q <= 1'b0;
      enable_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      div_q     <= div_d;
      snap_q    <= snap_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      pressed_q <= pressed_d;
      enable_q  <= enable_d;
    end
  end

  // FIFO storage, pointers and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 4'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_if.sv
// tb_keypad_scan_if: frame-level reference model plus scoreboard for keypad_scan_if.
module tb_keypad_scan_if;
  localparam int SCAN_DIV = 4;
  localparam int DB       = 2;
  localparam int DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  A;
  logic        WE;
  logic [31:0] InData;
  logic [31:0] OutData;
  logic        done_sig;
  logic [3:0]  col_n;
  logic [3:0]  row_n;

  logic [1:0]  main_a;
  logic        main_we;
  logic [31:0] main_data;
  logic [1:0]  mon_a;
  logic        mon_we;
  logic        mon_enable;
  logic [15:0] keys;

  int checks = 0;
  int fails  = 0;

  logic [3:0]  model_fifo [$];
  logic [15:0] hist [$];
  bit          model_pressed;
  bit          model_ovf;

  keypad_scan_if #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .A(A), .WE(WE), .InData(InData), .OutData(OutData),
    .done_sig(done_sig), .col_n(col_n), .row_n(row_n)
  );

  always #5 clk = ~clk;

  assign A      = mon_enable ? mon_a  : main_a;
  assign WE     = mon_enable ? mon_we : main_we;
  assign InData = mon_enable ? 32'd0  : main_data;

  // Keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_n = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_n[c] && keys[4*c+r]) row_n[r] = 1'b0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference model: one call per completed frame with the key set held during it
  function automatic void modelFrame(input logic [15:0] k);
    bit stable_run;
    int code;
    hist.push_back(k);
    if (hist.size() > DB) void'(hist.pop_front());
    stable_run = (hist.size() == DB);
    foreach (hist[i]) if (hist[i] != k) stable_run = 0;
    if (!model_pressed) begin
      if (stable_run && k != 16'd0) begin
        model_pressed = 1;
        if ($countones(k) == 1) begin
          code = 0;
          for (int i = 0; i < 16; i++) if (k[i]) code = i;
          if (model_fifo.size() < DEPTH) model_fifo.push_back(4'(code));
          else model_ovf = 1;
        end
      end
    end else if (stable_run && k == 16'd0) begin
      model_pressed = 0;
    end
  endfunction

  function automatic void modelReset();
    model_fifo.delete();
    hist.delete();
    model_pressed = 0;
    model_ovf = 0;
  endfunction

  function automatic logic [31:0] modelStatus();
    return {26'd0, 5'(model_fifo.size()), model_ovf};
  endfunction

  // Wait for the FRAME cycle, then return just after the following column-0 start
  task automatic syncBoundary();
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (col_n == 4'b1111) found = 1;
    end
    checks++;
    if (!found) begin
      fails++;
      $display("[TB] FAIL frame_sync: no frame cycle seen within 60 clocks");
    end else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int frames);
    for (int f = 0; f < frames; f++) begin
      keys = k;
      syncBoundary();
      modelFrame(k);
    end
  endtask

  task automatic finishFrame();
    syncBoundary();
    modelFrame(keys);
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    main_a = a;
    #1;
    d = OutData;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    main_a = a;
    main_data = d;
    main_we = 1'b1;
    @(posedge clk); #1;
    main_we = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [1:0] a, input logic [31:0] expected);
    logic [31:0] d;
    busRead(a, d);
    checkOutput(name, d, expected);
  endtask

  // Scoreboard monitor: whenever a key is pending, compare the head and pop it
  initial begin
    logic [3:0] exp_code;
    mon_a = 2'd1;
    mon_we = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_enable && done_sig) begin
        #1;
        if (model_fifo.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL scoreboard_unexpected: got key %h, expected none", OutData);
        end else begin
          exp_code = model_fifo.pop_front();
          checkOutput("scoreboard_key", OutData, {28'd0, exp_code});
        end
        mon_we = 1'b1;
        @(posedge clk); #1;
        mon_we = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] k;
    int b1, b2, r, frames;
    logic [31:0] d;
    main_a = 2'd0; main_we = 1'b0; main_data = 32'd0;
    mon_enable = 1'b0; keys = 16'd0; rst = 1'b0;
    modelReset();

    // Power-on reset state
    repeat (3) @(posedge clk); #1;
    checkOutput("reset_col_n", {28'd0, col_n}, 32'hF);
    checkOutput("reset_done", {31'd0, done_sig}, 32'd0);
    readCheck("reset_status", 2'd0, 32'd0);
    readCheck("reset_ctrl", 2'd2, 32'd1);
    readCheck("reset_data", 2'd1, 32'd0);
    readCheck("reset_raw", 2'd3, 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    checkOutput("scan_start_col0", {28'd0, col_n}, 32'hE);
    syncBoundary();
    modelFrame(16'd0);

    // Single press col2,row1, held without repeat, then popped
    applyStimulus(16'h0200, 3);
    readCheck("press_data", 2'd1, 32'h9);
    checkOutput("press_done", {31'd0, done_sig}, 32'd1);
    readCheck("press_status", 2'd0, 32'h2);
    applyStimulus(16'h0200, 10);
    readCheck("held_status", 2'd0, 32'h2);
    busWrite(2'd1, 32'hDEAD_BEEF);
    void'(model_fifo.pop_front());
    checkOutput("pop_done", {31'd0, done_sig}, 32'd0);
    readCheck("pop_status", 2'd0, 32'd0);
    finishFrame();
    applyStimulus(16'h0000, 3);

    // Bouncing key never stable long enough
    for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 16'h0001 : 16'h0000, 1);
    applyStimulus(16'h0000, 3);
    readCheck("bounce_status", 2'd0, 32'd0);

    // Two-key chord rejected, then a clean press col1,row2
    applyStimulus(16'h8001, 4);
    readCheck("chord_raw", 2'd3, 32'h8001);
    readCheck("chord_status", 2'd0, 32'd0);
    applyStimulus(16'h0000, 3);
    applyStimulus(16'h0040, 3);
    readCheck("after_chord_data", 2'd1, 32'h6);
    busWrite(2'd1, 32'd0);
    void'(model_fifo.pop_front());
    finishFrame();
    applyStimulus(16'h0000, 3);

    // Mid-frame reset with a key queued
    applyStimulus(16'h0008, 2);
    readCheck("prereset_status", 2'd0, 32'h2);
    repeat (5) @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset_col_n", {28'd0, col_n}, 32'hF);
    checkOutput("midreset_done", {31'd0, done_sig}, 32'd0);
    readCheck("midreset_status", 2'd0, 32'd0);
    readCheck("midreset_ctrl", 2'd2, 32'd1);
    keys = 16'd0;
    modelReset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    checkOutput("rescan_col0", {28'd0, col_n}, 32'hE);
    syncBoundary();
    modelFrame(16'd0);

    // Fill the FIFO, pop and push on the same frame edge, then overflow
    for (int c = 1; c <= 4; c++) begin
      k = 16'd0; k[c] = 1'b1;
      applyStimulus(k, 2);
      applyStimulus(16'h0000, 2);
    end
    readCheck("full_status", 2'd0, 32'h8);
    k = 16'd0; k[7] = 1'b1;
    applyStimulus(k, 1);
    readCheck("full_head", 2'd1, {28'd0, model_fifo[0]});
    for (int i = 0; i < 60 && col_n != 4'b1111; i++) begin
      @(posedge clk); #1;
    end
    main_a = 2'd1; main_we = 1'b1;
    @(posedge clk); #1;
    main_we = 1'b0;
    void'(model_fifo.pop_front());
    modelFrame(k);
    readCheck("pop_push_status", 2'd0, modelStatus());
    readCheck("pop_push_no_ovf", 2'd0, 32'h8);
    applyStimulus(16'h0000, 2);
    for (int c = 5; c <= 6; c++) begin
      k = 16'd0; k[c] = 1'b1;
      applyStimulus(k, 2);
      applyStimulus(16'h0000, 2);
    end
    readCheck("overflow_status", 2'd0, 32'h9);
    while (model_fifo.size() != 0) begin
      readCheck("drain_data", 2'd1, {28'd0, model_fifo[0]});
      busWrite(2'd1, 32'd0);
      void'(model_fifo.pop_front());
    end
    readCheck("drained_status", 2'd0, 32'h1);
    busWrite(2'd2, 32'd3);
    model_ovf = 0;
    readCheck("ovf_clear_status", 2'd0, 32'd0);
    readCheck("ovf_clear_ctrl", 2'd2, 32'd1);
    finishFrame();

    // Disable mid-column, press while disabled, resume at column 0
    repeat (6) @(posedge clk); #1;
    busWrite(2'd2, 32'd0);
    hist.delete();
    @(posedge clk); #1;
    checkOutput("disabled_col_n", {28'd0, col_n}, 32'hF);
    keys = 16'h0020;
    repeat (60) @(posedge clk); #1;
    checkOutput("disabled_hold_col_n", {28'd0, col_n}, 32'hF);
    readCheck("disabled_status", 2'd0, 32'd0);
    readCheck("disabled_ctrl", 2'd2, 32'd0);
    keys = 16'd0;
    repeat (4) @(posedge clk); #1;
    busWrite(2'd2, 32'd1);
    for (int i = 0; i < 3 && col_n == 4'b1111; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("resume_col0", {28'd0, col_n}, 32'hE);
    syncBoundary();
    modelFrame(16'd0);
    readCheck("resume_status", 2'd0, 32'd0);

    // Randomized key activity checked by the scoreboard monitor
    mon_enable = 1'b1;
    for (int ep = 0; ep < 40; ep++) begin
      r = $urandom_range(0, 99);
      k = 16'd0;
      b1 = $urandom_range(0, 15);
      if (r >= 35) k[b1] = 1'b1;
      if (r >= 85) begin
        b2 = (b1 + $urandom_range(1, 15)) % 16;
        k[b2] = 1'b1;
      end
      frames = $urandom_range(1, 4);
      applyStimulus(k, frames);
    end
    applyStimulus(16'h0000, 3);
    repeat (10) @(posedge clk); #1;
    mon_enable = 1'b0;
    checkOutput("scoreboard_drained", 32'(model_fifo.size()), 32'd0);
    busRead(2'd0, d);
    checkOutput("random_end_status", d, modelStatus());

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
